// File: rtl/pe_pkg.sv
// Shared types and constants for the processing element.
package pe_pkg;

  localparam int unsigned DATA_W = 8;

  typedef logic [DATA_W-1:0]   data_t;
  typedef logic [2*DATA_W-1:0] prod_t;

  localparam data_t ACC_MAX = '1;

endpackage

// File: rtl/pe_mac.sv
// Multiply-accumulate lane: acc <= acc + x*y, held when enable is low.
// Macro PE_SATURATE_EN selects clamping to all-ones instead of wrapping.
module pe_mac
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = pe_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] acc
);

  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   acc_next;

  assign prod = x * y;

`ifdef PE_SATURATE_EN
  localparam logic [2*DATA_W:0] SAT_LIMIT = {{(DATA_W+1){1'b0}}, {DATA_W{1'b1}}};

  logic [2*DATA_W:0] sum;

  assign sum = {{(DATA_W+1){1'b0}}, acc} + {1'b0, prod};

  // Clamp the extended sum; once at all-ones any further product keeps it there.
  always_comb begin
    acc_next = sum[DATA_W-1:0];
    if (sum > SAT_LIMIT) begin
      acc_next = '1;
    end
  end
`else
  // Wrapping accumulation keeps only the low DATA_W bits of acc + product.
  always_comb begin
    acc_next = DATA_W'({{DATA_W{1'b0}}, acc} + prod);
  end
`endif

  // Accumulator register: reset, then enable, then hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc <= '0;
    end else if (enable) begin
      acc <= acc_next;
    end
  end

endmodule

// File: rtl/pe.sv
// Systolic array processing element: forwards a/b/c through registers and
// runs two MAC lanes sharing operand a. Macro PE_SATURATE_EN selects
// saturating accumulators (see pe_mac).
module pe
  import pe_pkg::*;
#(
  parameter int unsigned DATA_W = pe_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] c,
  output logic [DATA_W-1:0] e,
  output logic [DATA_W-1:0] f,
  output logic [DATA_W-1:0] g,
  output logic [DATA_W-1:0] acc1,
  output logic [DATA_W-1:0] acc2
);

  // Forwarding registers toward the neighbouring cells.
  always_ff @(posedge clk) begin
    if (reset) begin
      e <= '0;
      f <= '0;
      g <= '0;
    end else if (enable) begin
      e <= a;
      f <= b;
      g <= c;
    end
  end

  pe_mac #(.DATA_W(DATA_W)) u_mac1 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .x      (a),
    .y      (b),
    .acc    (acc1)
  );

  pe_mac #(.DATA_W(DATA_W)) u_mac2 (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .x      (a),
    .y      (c),
    .acc    (acc2)
  );

endmodule

// File: tb/tb_pe.sv
// Scoreboard bench for pe: driver pushes expected outputs, monitor pops and compares.
module tb_pe;
  import pe_pkg::*;

  typedef struct {
    int    step;
    data_t e, f, g, acc1, acc2;
  } exp_t;

  logic  clk = 1'b0;
  logic  reset, enable;
  data_t a, b, c;
  data_t e, f, g, acc1, acc2;

  exp_t  sb[$];
  int    checks = 0;
  int    failures = 0;
  int    step_no = 0;

  // Reference state kept as plain integers.
  int unsigned m_e = 0, m_f = 0, m_g = 0, m_acc1 = 0, m_acc2 = 0;

  always #5 clk = ~clk;

  pe #(.DATA_W(8)) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .a      (a),
    .b      (b),
    .c      (c),
    .e      (e),
    .f      (f),
    .g      (g),
    .acc1   (acc1),
    .acc2   (acc2)
  );

  function automatic int unsigned accumulate(int unsigned acc, int unsigned prod);
    int unsigned s;
    s = acc + prod;
`ifdef PE_SATURATE_EN
    return (s > 255) ? 255 : s;
`else
    return s % 256;
`endif
  endfunction

  function automatic void check(int step, string name, data_t got, data_t want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL step=%0d %s got=%02h exp=%02h", step, name, got, want);
    end
  endfunction

  // Drive one edge's inputs and record the outputs expected after that edge.
  task automatic step(input logic r, input logic en, input data_t ai, input data_t bi, input data_t ci);
    exp_t x;
    @(negedge clk);
    reset  = r;
    enable = en;
    a = ai; b = bi; c = ci;
    if (r) begin
      m_e = 0; m_f = 0; m_g = 0; m_acc1 = 0; m_acc2 = 0;
    end else if (en) begin
      m_acc1 = accumulate(m_acc1, ai * bi);
      m_acc2 = accumulate(m_acc2, ai * ci);
      m_e = ai; m_f = bi; m_g = ci;
    end
    step_no++;
    x.step = step_no;
    x.e = data_t'(m_e); x.f = data_t'(m_f); x.g = data_t'(m_g);
    x.acc1 = data_t'(m_acc1); x.acc2 = data_t'(m_acc2);
    sb.push_back(x);
  endtask

  // Monitor: compare one scoreboard entry just after each rising edge.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        x = sb.pop_front();
        check(x.step, "e",    e,    x.e);
        check(x.step, "f",    f,    x.f);
        check(x.step, "g",    g,    x.g);
        check(x.step, "acc1", acc1, x.acc1);
        check(x.step, "acc2", acc2, x.acc2);
      end
    end
  end

  initial begin
    int unsigned wait_cycles;
    reset = 1'b1; enable = 1'b0; a = '0; b = '0; c = '0;

    // Reset with random inputs for two edges.
    for (int i = 0; i < 2; i++)
      step(1'b1, 1'(($urandom)), 8'($urandom), 8'($urandom), 8'($urandom));
    // Single step then accumulate with the same operands.
    step(1'b0, 1'b1, 8'h3D, 8'h2A, 8'h1F);
    step(1'b0, 1'b1, 8'h3D, 8'h2A, 8'h1F);
    // Hold for five edges with different inputs.
    for (int i = 0; i < 5; i++)
      step(1'b0, 1'b0, 8'h03, 8'hFF, 8'h01);
    // Mid-run reset with enable high, then a small product.
    step(1'b1, 1'b1, 8'h55, 8'h66, 8'h77);
    step(1'b0, 1'b1, 8'h02, 8'h03, 8'h04);
    step(1'b0, 1'b1, 8'h01, 8'h01, 8'h01);

    // Randomized traffic, small operands sometimes so wrap/saturate both occur.
    for (int i = 0; i < 400; i++) begin
      logic  r, en;
      data_t ai, bi, ci;
      r  = ($urandom_range(31) == 0);
      en = ($urandom_range(3) != 0);
      ai = ($urandom_range(1) == 0) ? 8'($urandom_range(3)) : 8'($urandom);
      bi = 8'($urandom);
      ci = ($urandom_range(1) == 0) ? 8'($urandom_range(3)) : 8'($urandom);
      step(r, en, ai, bi, ci);
    end

    // Let the monitor drain the scoreboard, bounded.
    wait_cycles = 0;
    while (sb.size() > 0 && wait_cycles < 20) begin
      @(posedge clk);
      wait_cycles++;
    end
    #2;
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain pending=%0d exp=0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
